des_round_engine: RTL and testbench
===================================

Name: des_round_engine

Overview:
- Iterative DES Feistel core, one round per clock.
- Consumes the permuted 32-bit left/right halves from the initial-permutation stage.
- Fetches one 48-bit subkey per round from the key-schedule block via a round-index/subkey port pair.
- Emits the swapped pre-output block R16||L16 to the final-permutation stage.

Parameters:
- ROUNDS, 16, number of Feistel rounds executed per block; legal range 1..16; standard DES uses 16.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- left_data_in  input  32  L0 from the initial-permutation stage.
- right_data_in  input  32  R0 from the initial-permutation stage.
- data_in_valid  input  1  single-cycle qualifier for left/right inputs; no backpressure upstream.
- decrypt_in  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
- ready_out  input-side status, output  1  high when a block can be accepted this cycle.
- round_idx_out  output  4  subkey index requested this cycle (0 = K1 … 15 = K16).
- subkey_in  input  48  subkey for round_idx_out; combinational, valid in the same cycle.
- left_data_out  output  32  R_ROUNDS (swapped).
- right_data_out  output  32  L_ROUNDS (swapped).
- data_out_valid  output  1  one-cycle pulse, result valid.
- overflow_out  output  1  sticky: a block arrived while busy and was dropped.

Behaviour:
- Reset: clk_in and rst_n_in as already decided (rst_n_in asynchronous, active-low; clock clk_in).
  - Reset clears all state and outputs to 0; ready_out = 1; state = IDLE.
  - Reset mid-operation discards the in-flight block; no output pulse.
- States: IDLE, ROUND.
- Accept condition: data_in_valid && ready_out (IDLE only).
  - On accept: L <= left_data_in; R <= right_data_in; cnt <= 0; mode <= decrypt_in; state <= ROUND; ready_out <= 0.
- ROUND, each cycle:
  - round_idx_out = mode ? ROUNDS-1-cnt : cnt (combinational).
  - L <= R; R <= L ^ f(R, subkey_in); cnt <= cnt+1.
- f function:
  - Expand R 32->48 with standard DES E table; XOR with subkey.
  - 8 standard DES S-boxes (6->4); outer bits select the row, inner 4 bits select the column.
  - Standard DES P permutation 32->32.
  - Bit numbering follows the DES standard, with bit 1 = MSB of each vector.
- Last round (cnt == ROUNDS-1) edge:
  - left_data_out <= new R; right_data_out <= new L.
  - data_out_valid <= 1 for exactly one cycle.
  - state <= IDLE; ready_out <= 1.
- Latency: accept at edge T; data_out_valid is high in the cycle after edge T+ROUNDS, i.e. 16 cycles for the default.
- Back-to-back: a new block may be accepted in the same cycle data_out_valid is high.
  - Throughput: one block per ROUNDS cycles.
- Outputs hold their last result until the next completion; data_out_valid is 0 otherwise.
- Busy input: data_in_valid while ready_out = 0 is ignored and sets overflow_out = 1.
  - overflow_out is cleared only by reset.
  - The current computation is unaffected.
- In IDLE, round_idx_out = 0; L, R and cnt hold.
- decrypt_in changing mid-block has no effect.

Test Plan:
- Reset, then idle 5 cycles -> ready_out = 1; all other outputs = 0; no valid pulse.
- Encrypt: bench key-schedule model for key 133457799BBCDFF1 (K1 = 1B02EFFC7072); L0 = CC00CCFF, R0 = F0AAF0AA, decrypt_in = 0.
  - Required: round_idx_out = 0..15 in order.
  - Required: left_data_out = 0A4CD995, right_data_out = 43423234, valid exactly 16 cycles after accept.
- Decrypt, same key: L0 = 0A4CD995, R0 = 43423234, decrypt_in = 1.
  - Required: round_idx_out = 15..0.
  - Required: outputs CC00CCFF / F0AAF0AA.
- Back-to-back: second block presented in the cycle of the first data_out_valid -> accepted.
  - Required: second result 16 cycles later; overflow_out stays 0.
- Busy drop: valid pulse 5 cycles after an accept -> overflow_out = 1 and stays set.
  - Required: first result unchanged (0A4CD995/43423234); only one valid pulse.
- Reset asserted at round 8, released 2 cycles later -> no valid pulse; outputs 0; ready_out = 1.
  - Required: a fresh encrypt afterwards yields the correct 0A4CD995/43423234.

Source files
------------

// File: rtl/des_round_engine.sv
// des_round_engine
// Iterative DES Feistel core that executes one round per clock. It takes the
// two halves produced by the initial permutation, pulls one 48-bit subkey per
// round from the key schedule, and hands R_ROUNDS||L_ROUNDS (already swapped)
// to the final permutation.
//
// Ports
//   clk_in          clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   left_data_in    L0 from the initial permutation
//   right_data_in   R0 from the initial permutation
//   data_in_valid   one-cycle qualifier for the input halves (no backpressure)
//   decrypt_in      0 = encrypt, 1 = decrypt, captured on accept
//   ready_out       a block can be accepted this cycle
//   round_idx_out   subkey index requested this cycle (0 = K1 .. 15 = K16)
//   subkey_in       subkey for round_idx_out, valid in the same cycle
//   left_data_out   R_ROUNDS
//   right_data_out  L_ROUNDS
//   data_out_valid  one-cycle result pulse
//   overflow_out    sticky: a block arrived while busy and was dropped
//
// State  | meaning
// IDLE   | waiting for a block; L, R and the round counter hold
// ROUND  | one Feistel round per cycle until the last round completes
module des_round_engine #(
  parameter int ROUNDS = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] left_data_in,
  input  logic [31:0] right_data_in,
  input  logic        data_in_valid,
  input  logic        decrypt_in,
  output logic        ready_out,
  output logic [3:0]  round_idx_out,
  input  logic [47:0] subkey_in,
  output logic [31:0] left_data_out,
  output logic [31:0] right_data_out,
  output logic        data_out_valid,
  output logic        overflow_out
);

  typedef enum logic {IDLE = 1'b0, ROUND = 1'b1} state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  // Tables list DES bit numbers (1 = MSB); they are consumed by shifting so
  // no variable-width selects are needed.
  localparam logic [287:0] E_TAB = {
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
    6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
    6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1};

  localparam logic [191:0] P_TAB = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25};

  // S1 in the top 256 bits; each box is row-major, entry 0 in its top nibble.
  localparam logic [2047:0] SBOX_ALL = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [287:0]  et;
    logic [191:0]  pt;
    logic [2047:0] sb;
    logic [255:0]  box;
    logic [47:0]   ex;
    logic [31:0]   s;
    logic [31:0]   p;
    logic [5:0]    chunk;
    logic [4:0]    idx;
    et = E_TAB;
    ex = '0;
    for (int i = 0; i < 48; i++) begin
      idx = 5'(6'd32 - et[287:282]);
      ex  = {ex[46:0], r[idx]};
      et  = et << 6;
    end
    ex = ex ^ k;
    sb = SBOX_ALL;
    s  = '0;
    for (int j = 0; j < 8; j++) begin
      chunk = ex[47:42];
      ex    = ex << 6;
      // outer bits pick the row, inner four the column; 4 bits per entry
      box   = sb[2047:1792] << {chunk[5], chunk[0], chunk[4:1], 2'b00};
      s     = {s[27:0], box[255:252]};
      sb    = sb << 256;
    end
    pt = P_TAB;
    p  = '0;
    for (int i = 0; i < 32; i++) begin
      idx = 5'(6'd32 - pt[191:186]);
      p   = {p[30:0], s[idx]};
      pt  = pt << 6;
    end
    return p;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [31:0] lout_q, lout_d, rout_q, rout_d;
  logic        valid_q, valid_d;
  logic        ovf_q, ovf_d;
  logic [31:0] f_out;
  logic [31:0] r_new;

  assign f_out = des_f(r_q, subkey_in);
  assign r_new = l_q ^ f_out;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      l_q     <= '0;
      r_q     <= '0;
      lout_q  <= '0;
      rout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      l_q     <= l_d;
      r_q     <= r_d;
      lout_q  <= lout_d;
      rout_q  <= rout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    l_d     = l_q;
    r_d     = r_q;
    lout_d  = lout_q;
    rout_d  = rout_q;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          l_d     = left_data_in;
          r_d     = right_data_in;
          cnt_d   = '0;
          mode_d  = decrypt_in;
          state_d = ROUND;
        end
      end
      ROUND: begin
        // a block offered while busy is dropped and flagged
        if (data_in_valid) ovf_d = 1'b1;
        l_d   = r_q;
        r_d   = r_new;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          lout_d  = r_new;
          rout_d  = r_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_out      = (state_q == IDLE);
  assign round_idx_out  = (state_q == ROUND) ? (mode_q ? (LAST - cnt_q) : cnt_q) : 4'd0;
  assign left_data_out  = lout_q;
  assign right_data_out = rout_q;
  assign data_out_valid = valid_q;
  assign overflow_out   = ovf_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Directed bench for des_round_engine. A key-schedule model supplies subkeys
// combinationally from round_idx_out; expected results and round indices are
// queued when a block is driven and checked when the engine produces them.
module tb_des_round_engine;

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT  = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] CT  = 64'h0A4CD995_43423234;

  localparam logic [335:0] PC1 = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4};

  localparam logic [287:0] PC2 = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  // 1 = rotate by two for that round (K1 first)
  localparam logic [15:0] SH2 = 16'b0011_1111_0111_1110;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [31:0] left_data_in = '0;
  logic [31:0] right_data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        decrypt_in = 1'b0;
  logic        ready_out;
  logic [3:0]  round_idx_out;
  logic [47:0] subkey_in;
  logic [31:0] left_data_out;
  logic [31:0] right_data_out;
  logic        data_out_valid;
  logic        overflow_out;

  logic [47:0] ks [16];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcount = 0;
  int v0 = 0;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] idx_q[$];

  logic [335:0] t1;
  logic [287:0] t2;
  logic [55:0]  cd;
  logic [27:0]  c_h, d_h;
  logic [47:0]  k_w;
  logic [15:0]  sh;
  logic [5:0]   ix;

  always #5 clk_in = ~clk_in;

  des_round_engine #(.ROUNDS(16)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .left_data_in  (left_data_in),
    .right_data_in (right_data_in),
    .data_in_valid (data_in_valid),
    .decrypt_in    (decrypt_in),
    .ready_out     (ready_out),
    .round_idx_out (round_idx_out),
    .subkey_in     (subkey_in),
    .left_data_out (left_data_out),
    .right_data_out(right_data_out),
    .data_out_valid(data_out_valid),
    .overflow_out  (overflow_out)
  );

  assign subkey_in = ks[round_idx_out];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns one negedge later.
  task automatic send(input logic [31:0] l, input logic [31:0] r, input logic dec,
                      input logic [63:0] exp, input logic expect_accept);
    left_data_in  = l;
    right_data_in = r;
    decrypt_in    = dec;
    data_in_valid = 1'b1;
    if (expect_accept) begin
      sb_q.push_back('{data: exp, cyc: cyc + 17});
      for (int k = 0; k < 16; k++)
        idx_q.push_back(dec ? 4'(15 - k) : 4'(k));
    end
    @(negedge clk_in);
    data_in_valid = 1'b0;
    decrypt_in    = ~dec;
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      cyc++;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in) begin
        if (!ready_out) begin
          if (idx_q.size() == 0) check("busy_unexpected", 64'(ready_out), 64'd1);
          else check("round_idx", 64'(round_idx_out), 64'(idx_q.pop_front()));
        end
        if (data_out_valid) begin
          vcount++;
          if (sb_q.size() == 0) begin
            check("valid_unexpected", 64'(data_out_valid), 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("result", {left_data_out, right_data_out}, e.data);
            check("latency_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    // key schedule model
    t1 = PC1;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      ix = 6'(7'd64 - 7'(t1[335:330]));
      cd = {cd[54:0], KEY[ix]};
      t1 = t1 << 6;
    end
    c_h = cd[55:28];
    d_h = cd[27:0];
    sh  = SH2;
    for (logic [4:0] n = 5'd0; n < 5'd16; n++) begin
      c_h = {c_h[26:0], c_h[27]};
      d_h = {d_h[26:0], d_h[27]};
      if (sh[15]) begin
        c_h = {c_h[26:0], c_h[27]};
        d_h = {d_h[26:0], d_h[27]};
      end
      sh  = sh << 1;
      cd  = {c_h, d_h};
      t2  = PC2;
      k_w = '0;
      for (int i = 0; i < 48; i++) begin
        ix  = 6'(7'd56 - 7'(t2[287:282]));
        k_w = {k_w[46:0], cd[ix]};
        t2  = t2 << 6;
      end
      ks[n[3:0]] = k_w;
    end

    // reset and idle
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);
    check("reset_ready", 64'(ready_out), 64'd1);
    check("reset_left", 64'(left_data_out), 64'd0);
    check("reset_right", 64'(right_data_out), 64'd0);
    check("reset_valid", 64'(data_out_valid), 64'd0);
    check("reset_idx", 64'(round_idx_out), 64'd0);
    check("reset_ovf", 64'(overflow_out), 64'd0);
    check("reset_no_pulse", 64'(vcount), 64'd0);

    // encrypt
    send(PT[63:32], PT[31:0], 1'b0, CT, 1'b1);
    repeat (17) @(negedge clk_in);
    check("enc_drained", 64'(sb_q.size()), 64'd0);
    check("enc_idx_drained", 64'(idx_q.size()), 64'd0);
    check("enc_hold", {left_data_out, right_data_out}, CT);
    check("enc_valid_low", 64'(data_out_valid), 64'd0);

    // decrypt
    send(CT[63:32], CT[31:0], 1'b1, PT, 1'b1);
    repeat (17) @(negedge clk_in);
    check("dec_drained", 64'(sb_q.size()), 64'd0);
    check("dec_hold", {left_data_out, right_data_out}, PT);

    // back-to-back: second block offered in the cycle of the first pulse
    v0 = vcount;
    send(PT[63:32], PT[31:0], 1'b0, CT, 1'b1);
    repeat (16) @(negedge clk_in);
    check("b2b_first_valid", 64'(data_out_valid), 64'd1);
    check("b2b_ready", 64'(ready_out), 64'd1);
    send(CT[63:32], CT[31:0], 1'b1, PT, 1'b1);
    repeat (17) @(negedge clk_in);
    check("b2b_drained", 64'(sb_q.size()), 64'd0);
    check("b2b_pulses", 64'(vcount - v0), 64'd2);
    check("b2b_ovf", 64'(overflow_out), 64'd0);

    // busy drop
    v0 = vcount;
    send(PT[63:32], PT[31:0], 1'b0, CT, 1'b1);
    repeat (4) @(negedge clk_in);
    send(32'h12345678, 32'h9ABCDEF0, 1'b1, 64'd0, 1'b0);
    check("busy_ovf_set", 64'(overflow_out), 64'd1);
    repeat (12) @(negedge clk_in);
    check("busy_drained", 64'(sb_q.size()), 64'd0);
    check("busy_one_pulse", 64'(vcount - v0), 64'd1);
    check("busy_result", {left_data_out, right_data_out}, CT);
    check("busy_ovf_sticky", 64'(overflow_out), 64'd1);

    // reset in the middle of a block
    send(PT[63:32], PT[31:0], 1'b0, CT, 1'b1);
    repeat (7) @(negedge clk_in);
    rst_n_in = 1'b0;
    sb_q.delete();
    idx_q.delete();
    v0 = vcount;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_outputs", {left_data_out, right_data_out}, 64'd0);
    check("rst_ovf", 64'(overflow_out), 64'd0);
    check("rst_idx", 64'(round_idx_out), 64'd0);
    repeat (20) @(negedge clk_in);
    check("rst_no_pulse", 64'(vcount - v0), 64'd0);
    check("rst_valid_low", 64'(data_out_valid), 64'd0);

    // fresh encrypt after reset
    send(PT[63:32], PT[31:0], 1'b0, CT, 1'b1);
    repeat (17) @(negedge clk_in);
    check("fresh_drained", 64'(sb_q.size()), 64'd0);
    check("fresh_idx_drained", 64'(idx_q.size()), 64'd0);
    check("fresh_result", {left_data_out, right_data_out}, CT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
